// File: rtl/vrf_pkg.sv
// Shared defaults and record types for the vector register file write path.
package vrf_pkg;

  localparam int NUM_REQ_DEF      = 4;
  localparam int NUM_WR_PORTS_DEF = 2;
  localparam int NUM_REG_DEF      = 32;
  localparam int DATA_SIZE_DEF    = 2048;
  localparam int ADDRESS_DEF      = $clog2(NUM_REG_DEF);

  // One pending register write as presented by a functional unit
  // (default-width view; parameterised instances carry the same three fields).
  typedef struct packed {
    logic [ADDRESS_DEF-1:0]     addr;
    logic [DATA_SIZE_DEF-1:0]   data;
    logic [DATA_SIZE_DEF/8-1:0] strb;
  } vrf_req_t;

  // Index width for a set of n items; never collapses to zero bits.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vrf_wr_grant.sv
// Combinational round-robin grant and write-port assignment.
// Requesters are scanned starting at rr_ptr; the k-th winner takes port k.
// A requester loses when all ports are taken or its address collides with
// an address already granted in this scan.
module vrf_wr_grant
  import vrf_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int NUM_WR_PORTS = NUM_WR_PORTS_DEF,
  parameter int ADDRESS      = ADDRESS_DEF,
  parameter int PTR_W        = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ-1:0][ADDRESS-1:0]         req_addr,
  input  logic [PTR_W-1:0]                        rr_ptr,
  output logic [NUM_REQ-1:0]                      grant,
  output logic [NUM_WR_PORTS-1:0]                 port_valid,
  output logic [NUM_WR_PORTS-1:0][PTR_W-1:0]      port_sel,
  output logic                                    any_grant,
  output logic [PTR_W-1:0]                        last_idx,
  output logic                                    addr_conflict
);

  logic [NUM_WR_PORTS-1:0][ADDRESS-1:0] port_addr;

  // Scan requesters in rotated order, filling ports and detecting address hits.
  always_comb begin
    int               n_used;
    logic [PTR_W-1:0] idx;
    logic             hit;
    grant         = '0;
    port_valid    = '0;
    port_sel      = '0;
    port_addr     = '0;
    any_grant     = 1'b0;
    last_idx      = '0;
    addr_conflict = 1'b0;
    n_used        = 0;
    idx           = '0;
    hit           = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      // A port-limit loss is not a conflict, so address checks only run
      // while a port is still free.
      if (req_valid[idx] && (n_used < NUM_WR_PORTS)) begin
        hit = 1'b0;
        for (int k = 0; k < NUM_WR_PORTS; k++) begin
          if ((k < n_used) && (port_addr[k] == req_addr[idx])) hit = 1'b1;
        end
        if (hit) begin
          addr_conflict = 1'b1;
        end else begin
          for (int k = 0; k < NUM_WR_PORTS; k++) begin
            if (k == n_used) begin
              port_valid[k] = 1'b1;
              port_sel[k]   = idx;
              port_addr[k]  = req_addr[idx];
            end
          end
          grant[idx] = 1'b1;
          any_grant  = 1'b1;
          last_idx   = idx;
          n_used     = n_used + 1;
        end
      end
    end
  end

endmodule

// File: rtl/vrf_wr_arbiter.sv
// Vector register file write arbiter: several functional units compete for
// a smaller number of VRF write ports. Handshake: a requester holds
// valid/addr/data/strb until it sees req_ready high in the same cycle as
// req_valid; that cycle is the transfer, and the write appears on wr_* one
// cycle later. Rejected requests are not buffered here.
module vrf_wr_arbiter
  import vrf_pkg::*;
#(
  parameter  int NUM_REQ      = NUM_REQ_DEF,
  parameter  int NUM_WR_PORTS = NUM_WR_PORTS_DEF,
  parameter  int NUM_REG      = NUM_REG_DEF,
  parameter  int DATA_SIZE    = DATA_SIZE_DEF,
  localparam int ADDRESS      = $clog2(NUM_REG),
  localparam int STRB_W       = DATA_SIZE / 8,
  localparam int PTR_W        = ptr_width(NUM_REQ)
) (
  input  logic                                  clk,
  input  logic                                  arst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0][ADDRESS-1:0]       req_addr,
  input  logic [NUM_REQ-1:0][DATA_SIZE-1:0]     req_data,
  input  logic [NUM_REQ-1:0][STRB_W-1:0]        req_strb,
  output logic [NUM_WR_PORTS-1:0]               wr_en,
  output logic [NUM_WR_PORTS-1:0][ADDRESS-1:0]  wr_addr,
  output logic [NUM_WR_PORTS-1:0][DATA_SIZE-1:0] wr_data,
  output logic [NUM_WR_PORTS-1:0][STRB_W-1:0]   wr_strb,
  output logic [NUM_REG-1:0]                    wr_pending,
  output logic [15:0]                           conflict_cnt,
  output logic [PTR_W-1:0]                      dbg_rr_ptr
);

  logic [NUM_REQ-1:0]                    grant;
  logic [NUM_WR_PORTS-1:0]               port_valid;
  logic [NUM_WR_PORTS-1:0][PTR_W-1:0]    port_sel;
  logic                                  any_grant;
  logic [PTR_W-1:0]                      last_idx;
  logic                                  addr_conflict;

  logic [PTR_W-1:0]                      rr_ptr_q, rr_ptr_d;
  logic [15:0]                           conflict_cnt_q, conflict_cnt_d;
  logic [NUM_WR_PORTS-1:0]               wr_en_q, wr_en_d;
  logic [NUM_WR_PORTS-1:0][ADDRESS-1:0]  wr_addr_q, wr_addr_d;
  logic [NUM_WR_PORTS-1:0][DATA_SIZE-1:0] wr_data_q, wr_data_d;
  logic [NUM_WR_PORTS-1:0][STRB_W-1:0]   wr_strb_q, wr_strb_d;

  vrf_wr_grant #(
    .NUM_REQ      (NUM_REQ),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .ADDRESS      (ADDRESS),
    .PTR_W        (PTR_W)
  ) u_grant (
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .rr_ptr        (rr_ptr_q),
    .grant         (grant),
    .port_valid    (port_valid),
    .port_sel      (port_sel),
    .any_grant     (any_grant),
    .last_idx      (last_idx),
    .addr_conflict (addr_conflict)
  );

  // Grants are suppressed while reset is held so nothing is accepted into a
  // register that cannot capture it.
  assign req_ready = grant & {NUM_REQ{arst_n}};

  // Next-state: route winners onto ports, rotate pointer, count conflicts.
  always_comb begin
    wr_en_d   = '0;
    wr_addr_d = '0;
    wr_data_d = '0;
    wr_strb_d = '0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      if (port_valid[k]) begin
        wr_en_d[k]   = 1'b1;
        wr_addr_d[k] = req_addr[port_sel[k]];
        wr_data_d[k] = req_data[port_sel[k]];
        wr_strb_d[k] = req_strb[port_sel[k]];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
    end
    conflict_cnt_d = conflict_cnt_q;
    if (addr_conflict && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_ptr_q       <= '0;
      conflict_cnt_q <= '0;
      wr_en_q        <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_strb_q      <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      conflict_cnt_q <= conflict_cnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_strb_q      <= wr_strb_d;
    end
  end

  // Decode the registered writes into a per-register busy mask.
  always_comb begin
    wr_pending = '0;
    for (int k = 0; k < NUM_WR_PORTS; k++) begin
      if (wr_en_q[k]) wr_pending[wr_addr_q[k]] = 1'b1;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign wr_strb      = wr_strb_q;
  assign conflict_cnt = conflict_cnt_q;
  assign dbg_rr_ptr   = rr_ptr_q;

endmodule

// File: tb/tb_vrf_wr_arbiter.sv
// Testbench for vrf_wr_arbiter: vector table, hand sequences, random traffic.
module tb_vrf_wr_arbiter;

  localparam int NR   = 4;
  localparam int NP   = 2;
  localparam int NREG = 32;
  localparam int DS   = 64;
  localparam int AW   = 5;
  localparam int SW   = 8;
  localparam int RW   = AW + DS + SW;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]          req_valid;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DS-1:0]  req_data;
  logic [NR-1:0][SW-1:0]  req_strb;
  logic [NP-1:0]          wr_en;
  logic [NP-1:0][AW-1:0]  wr_addr;
  logic [NP-1:0][DS-1:0]  wr_data;
  logic [NP-1:0][SW-1:0]  wr_strb;
  logic [NREG-1:0]        wr_pending;
  logic [15:0]            conflict_cnt;
  logic [1:0]             dbg_rr_ptr;

  vrf_wr_arbiter #(
    .NUM_REQ(NR), .NUM_WR_PORTS(NP), .NUM_REG(NREG), .DATA_SIZE(DS)
  ) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_pending(wr_pending), .conflict_cnt(conflict_cnt), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- scoreboard / model state ----------------
  int n_chk  = 0;
  int n_fail = 0;
  logic [RW-1:0] exp_q[$];
  int            m_rr;
  int unsigned   m_cc;
  int            m_grants[$];
  logic [NR-1:0] s_ready;
  int            gcount[NR];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk requesters from the pointer, a winner needs a free port
  // and an address not yet taken this cycle.
  task automatic model_arb(output logic [NR-1:0] g, output bit cf);
    int used[$];
    int idx;
    bit dup;
    m_grants.delete();
    g  = '0;
    cf = 1'b0;
    for (int i = 0; i < NR; i++) begin
      idx = (m_rr + i) % NR;
      if (req_valid[idx] && used.size() < NP) begin
        dup = 1'b0;
        foreach (used[j]) if (used[j] == int'(req_addr[idx])) dup = 1'b1;
        if (dup) cf = 1'b1;
        else begin
          used.push_back(int'(req_addr[idx]));
          m_grants.push_back(idx);
          g[idx] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DS-1:0] d, input logic [SW-1:0] s);
    req_valid[i] = v;
    req_addr[i]  = a;
    req_data[i]  = d;
    req_strb[i]  = s;
  endtask

  // Called at posedge+1 with inputs driven; checks ready, then the
  // registered result after the next edge; returns at posedge+1.
  task automatic cycle_check();
    logic [NR-1:0]   g;
    bit              cf;
    logic [NP-1:0]   mask;
    logic [NREG-1:0] pend;
    logic [RW-1:0]   rec;
    int              n;
    #1;
    model_arb(g, cf);
    s_ready = req_ready;
    chk("ready", {124'd0, req_ready}, {124'd0, g});
    foreach (m_grants[j]) begin
      exp_q.push_back({req_addr[m_grants[j]], req_data[m_grants[j]], req_strb[m_grants[j]]});
      gcount[m_grants[j]]++;
    end
    n = m_grants.size();
    if (n > 0) m_rr = (m_grants[n-1] + 1) % NR;
    if (cf && m_cc < 32'hFFFF) m_cc++;
    @(posedge clk);
    #1;
    mask = '0;
    pend = '0;
    for (int k = 0; k < NP; k++) begin
      if (k < n) begin
        mask[k] = 1'b1;
        rec = exp_q.pop_front();
        chk("wr_rec", {51'd0, wr_addr[k], wr_data[k], wr_strb[k]}, {51'd0, rec});
        pend[rec[RW-1 -: AW]] = 1'b1;
      end else begin
        chk("wr_idle", {51'd0, wr_addr[k], wr_data[k], wr_strb[k]}, 128'd0);
      end
    end
    chk("wr_en", {126'd0, wr_en}, {126'd0, mask});
    chk("wr_pending", {96'd0, wr_pending}, {96'd0, pend});
    chk("conflict_cnt", {112'd0, conflict_cnt}, 128'(m_cc));
    chk("rr_ptr", {126'd0, dbg_rr_ptr}, 128'(m_rr));
  endtask

  // Entered at posedge+1; leaves at posedge+1 with the DUT out of reset.
  task automatic do_reset();
    arst_n    = 1'b0;
    req_valid = '1;
    #2;
    chk("rst_ready", {124'd0, req_ready}, 128'd0);
    chk("rst_wr_en", {126'd0, wr_en}, 128'd0);
    chk("rst_wr_addr", {118'd0, wr_addr}, 128'd0);
    chk("rst_cc", {112'd0, conflict_cnt}, 128'd0);
    chk("rst_rr", {126'd0, dbg_rr_ptr}, 128'd0);
    req_valid = '0;
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    chk("rel_wr_en", {126'd0, wr_en}, 128'd0);
    @(posedge clk);
    #1;
    m_rr = 0;
    m_cc = 0;
    exp_q.delete();
    s_ready = '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [4:0]  a0, a1, a2, a3;
    logic [3:0]  ready;
    logic [15:0] cc;
    logic [1:0]  rr;
  } vec_t;
  vec_t vecs[10];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_addr = '0; req_data = '0; req_strb = '0;
    m_rr = 0; m_cc = 0; s_ready = '0;
    foreach (gcount[i]) gcount[i] = 0;

    vecs[0] = '{4'b1111, 5'd1, 5'd2, 5'd3, 5'd4, 4'b0011, 16'd0, 2'd2};
    vecs[1] = '{4'b0011, 5'd5, 5'd5, 5'd0, 5'd0, 4'b0001, 16'd1, 2'd1};
    vecs[2] = '{4'b1000, 5'd0, 5'd0, 5'd0, 5'd7, 4'b1000, 16'd0, 2'd0};
    vecs[3] = '{4'b0000, 5'd1, 5'd2, 5'd3, 5'd4, 4'b0000, 16'd0, 2'd0};
    vecs[4] = '{4'b1111, 5'd9, 5'd9, 5'd9, 5'd9, 4'b0001, 16'd1, 2'd1};
    vecs[5] = '{4'b0110, 5'd3, 5'd3, 5'd3, 5'd0, 4'b0010, 16'd1, 2'd2};
    vecs[6] = '{4'b1101, 5'd1, 5'd0, 5'd1, 5'd2, 4'b1001, 16'd1, 2'd0};
    vecs[7] = '{4'b0111, 5'd4, 5'd4, 5'd6, 5'd0, 4'b0101, 16'd1, 2'd3};
    vecs[8] = '{4'b1110, 5'd0, 5'd0, 5'd1, 5'd2, 4'b0110, 16'd0, 2'd3};
    vecs[9] = '{4'b1111, 5'd1, 5'd1, 5'd2, 5'd3, 4'b0101, 16'd1, 2'd3};

    @(posedge clk);
    #1;

    // Single-cycle vectors from a fresh reset each.
    for (int v = 0; v < 10; v++) begin
      do_reset();
      set_req(0, vecs[v].valid[0], vecs[v].a0, 64'h1000 + 64'(v), 8'hFF);
      set_req(1, vecs[v].valid[1], vecs[v].a1, 64'h2000 + 64'(v), 8'hF0);
      set_req(2, vecs[v].valid[2], vecs[v].a2, 64'h3000 + 64'(v), 8'h0F);
      set_req(3, vecs[v].valid[3], vecs[v].a3, 64'h4000 + 64'(v), 8'h00);
      cycle_check();
      chk("vec_ready", {124'd0, s_ready}, {124'd0, vecs[v].ready});
      chk("vec_cc", {112'd0, conflict_cnt}, {112'd0, vecs[v].cc});
      chk("vec_rr", {126'd0, dbg_rr_ptr}, {126'd0, vecs[v].rr});
    end

    // Two-cycle rotation over four distinct addresses.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'(i + 1), 64'hA0 + 64'(i), 8'hFF);
    cycle_check();
    chk("seq1_ready0", {124'd0, s_ready}, 128'b0011);
    chk("seq1_wr_en", {126'd0, wr_en}, 128'b11);
    chk("seq1_addr1", {123'd0, wr_addr[1]}, 128'd2);
    chk("seq1_addr0", {123'd0, wr_addr[0]}, 128'd1);
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    cycle_check();
    chk("seq1_ready1", {124'd0, s_ready}, 128'b1100);
    chk("seq1_rr", {126'd0, dbg_rr_ptr}, 128'd0);

    // Same-address pair: loser wins on the following cycle.
    do_reset();
    set_req(0, 1'b1, 5'd5, 64'h55, 8'h01);
    set_req(1, 1'b1, 5'd5, 64'h66, 8'h02);
    cycle_check();
    chk("seq2_ready0", {124'd0, s_ready}, 128'b0001);
    chk("seq2_cc", {112'd0, conflict_cnt}, 128'd1);
    req_valid[0] = 1'b0;
    cycle_check();
    chk("seq2_ready1", {124'd0, s_ready}, 128'b0010);
    chk("seq2_wr_data", {64'd0, wr_data[0]}, 128'h66);

    // Lone requester 3 lands on port 0.
    do_reset();
    set_req(3, 1'b1, 5'd17, 64'hDEAD_BEEF_0123_4567, 8'h0F);
    cycle_check();
    chk("seq3_wr_en", {126'd0, wr_en}, 128'b01);
    chk("seq3_addr", {123'd0, wr_addr[0]}, 128'd17);
    chk("seq3_data", {64'd0, wr_data[0]}, 128'hDEAD_BEEF_0123_4567);
    chk("seq3_strb", {120'd0, wr_strb[0]}, 128'h0F);
    chk("seq3_pending", {96'd0, wr_pending}, 128'h0002_0000);

    // Reset while both ports are busy and the counter is non-zero.
    do_reset();
    set_req(0, 1'b1, 5'd6, 64'h1, 8'h1);
    set_req(1, 1'b1, 5'd6, 64'h2, 8'h2);
    cycle_check();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'(i + 10), 64'(i), 8'hFF);
    cycle_check();
    chk("seq4_busy", {126'd0, wr_en}, 128'b11);
    chk("seq4_cc_pre", {112'd0, conflict_cnt}, 128'd1);
    do_reset();

    // Counter saturation from a preloaded near-maximum value.
    force dut.conflict_cnt_q = 16'hFFFE;
    #1;
    release dut.conflict_cnt_q;
    m_cc = 32'hFFFE;
    chk("seq5_preload", {112'd0, conflict_cnt}, 128'hFFFE);
    set_req(0, 1'b1, 5'd5, 64'h7, 8'h3);
    set_req(1, 1'b1, 5'd5, 64'h8, 8'h4);
    for (int c = 0; c < 3; c++) cycle_check();
    chk("seq5_sat", {112'd0, conflict_cnt}, 128'hFFFF);

    // Fairness: four distinct addresses always valid for 100 cycles.
    do_reset();
    foreach (gcount[i]) gcount[i] = 0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 5'(3 * i + 1), {$urandom, $urandom}, 8'(i));
    for (int c = 0; c < 100; c++) begin
      cycle_check();
      for (int i = 0; i < NR; i++)
        if (s_ready[i]) set_req(i, 1'b1, 5'(3 * i + 1), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < NR; i++) chk("fair_count", 128'(gcount[i]), 128'd50);

    // Random traffic with a narrow address range to provoke collisions.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || s_ready[i]) begin
          if ($urandom_range(0, 9) < 6)
            set_req(i, 1'b1, 5'($urandom_range(0, 7)), {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
          else
            req_valid[i] = 1'b0;
        end
      end
      cycle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vrf_wr_arbiter.md
VRF_WR_ARBITER -- requirements
Module: vrf_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of write requesters (functional units).
REQ-002 SHALL have parameter NUM_WR_PORTS, default 2: number of vrf write ports driven.
REQ-003 SHALL have parameter NUM_REG, default 32: vector registers; ADDRESS = $clog2(NUM_REG) is a localparam.
REQ-004 SHALL have parameter DATA_SIZE, default 2048: vector width, multiple of 8.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port arst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  input  [NUM_REQ]  requester has a write pending.
REQ-008 SHALL have port req_ready  output  [NUM_REQ]  grant this cycle; transfer when valid && ready.
REQ-009 SHALL have port req_addr  input  [ADDRESS] x NUM_REQ  destination register.
REQ-010 SHALL have port req_data  input  [DATA_SIZE] x NUM_REQ  write data.
REQ-011 SHALL have port req_strb  input  [DATA_SIZE/8] x NUM_REQ  byte strobes.
REQ-012 SHALL have port wr_en  output  1 x NUM_WR_PORTS  registered vrf write enable.
REQ-013 SHALL have ports wr_addr / wr_data / wr_strb  output  vrf-width x NUM_WR_PORTS  registered vrf write fields.
REQ-014 SHALL have port wr_pending  output  [NUM_REG]  bit r set when any wr_en port targets register r.
REQ-015 SHALL have port conflict_cnt  output  [16]  count of cycles with an address-conflict rejection.

Function
REQ-016 Grant scan SHALL visit requesters in order rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-017 A valid requester SHALL be granted if a free port remains and its addr differs from every addr already granted this cycle.
REQ-018 At most NUM_WR_PORTS grants per cycle; the k-th granted requester in scan order SHALL occupy port k.
REQ-019 req_ready SHALL be combinational from req_valid, req_addr and rr_ptr; it SHALL never be asserted without req_valid.
REQ-020 Granted fields SHALL appear on wr_* exactly 1 cycle after the grant; unused ports SHALL have wr_en=0 and zero fields.
REQ-021 No two asserted wr_en ports SHALL carry the same wr_addr in the same cycle.
REQ-022 rr_ptr SHALL advance to (last granted index + 1) mod NUM_REQ; with no grant it SHALL hold.
REQ-023 Requesters SHALL hold valid/addr/data/strb stable until accepted; the arbiter does not buffer rejected requests.
REQ-024 All-zero req_strb SHALL still be granted and forwarded unchanged.
REQ-025 wr_pending SHALL be derived combinationally from registered wr_en/wr_addr.
REQ-026 conflict_cnt SHALL increment by 1 in any cycle where a valid requester is rejected only because of an address match; it SHALL saturate at 16'hFFFF.
REQ-027 Port-limit rejections SHALL NOT increment conflict_cnt.

Reset
REQ-028 On arst_n low, asynchronously: wr_en=0, wr_addr/wr_data/wr_strb=0, rr_ptr=0, conflict_cnt=0.
REQ-029 Reset mid-operation SHALL drop the registered write; no wr_en in the first cycle after release.
REQ-030 req_ready SHALL be 0 while arst_n is low.

Structure
REQ-031 Parameter defaults and the request record typedef (addr, data, strb) SHALL live in shared package vrf_pkg.
REQ-032 The combinational grant/port-assignment logic SHALL be sub-module vrf_wr_grant; the top holds rr_ptr, output registers and counter.

Verification (NUM_REQ=4, NUM_WR_PORTS=2, NUM_REG=32, DATA_SIZE=64)
REQ-033 Reset, all valid, addrs 1,2,3,4 -> cycle 0 ready=0011; cycle 1 wr_en=11, wr_addr={2,1}, then ready=1100; rr_ptr back to 0.
REQ-034 Req0 and req1 both addr 5, others idle -> only req0 granted, conflict_cnt=1; req1 granted the next cycle.
REQ-035 Only req3 valid, strb=8'h0F -> port0 wr_en=1, addr/data/strb match, wr_pending has only bit addr set, one cycle later.
REQ-036 Four valid on four distinct addrs for 100 cycles -> every requester granted twice per 4 cycles, never starved.
REQ-037 arst_n low for one cycle while wr_en=11 -> wr_en=0 immediately, conflict_cnt=0, rr_ptr=0.
REQ-038 Force conflict_cnt to 16'hFFFE, cause 3 conflict cycles -> count holds at 16'hFFFF.
